// File: rtl/joy_serializer.sv
// rtl/joy_serializer.sv - 74HC165-style 24-bit serial joystick transmitter for two players
module joy_serializer #(
    parameter logic FILL_BIT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        joy_clk,
    input  logic        joy_load,
    input  logic [11:0] p1_btn,
    input  logic [11:0] p2_btn,
    output logic        joy_data,
    output logic        frame_strobe,
    output logic        frame_err,
    output logic [7:0]  frame_cnt
);

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t      state_q, state_d;

    logic        jclk_s1_q, jclk_s2_q, jclk_h_q;
    logic        jld_s1_q, jld_s2_q, jld_h_q;
    logic [11:0] p1_s1_q, p1_s2_q;
    logic [11:0] p2_s1_q, p2_s2_q;

    logic [23:0] sr_q, sr_d;
    logic [4:0]  shcnt_q, shcnt_d;
    logic        strobe_q, strobe_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        first_q, first_d;

    logic        clk_rise;
    logic        load_rise;
    logic        load_en;
    logic [23:0] load_word;

    assign clk_rise  = jclk_s2_q & ~jclk_h_q;
    assign load_rise = jld_s2_q & ~jld_h_q;

    // Head-to-tail order of the adapter board's 165 chain
    assign load_word = {p1_s2_q[8], p1_s2_q[6], p1_s2_q[5], p1_s2_q[4],
                        p1_s2_q[3], p1_s2_q[2], p1_s2_q[1], p1_s2_q[0],
                        p2_s2_q[8], p2_s2_q[6], p2_s2_q[5], p2_s2_q[4],
                        p2_s2_q[3], p2_s2_q[2], p2_s2_q[1], p2_s2_q[0],
                        p2_s2_q[10], p2_s2_q[11], p2_s2_q[9], p2_s2_q[7],
                        p1_s2_q[10], p1_s2_q[11], p1_s2_q[9], p1_s2_q[7]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jclk_s1_q <= 1'b1;
            jclk_s2_q <= 1'b1;
            jclk_h_q  <= 1'b1;
            jld_s1_q  <= 1'b1;
            jld_s2_q  <= 1'b1;
            jld_h_q   <= 1'b1;
            p1_s1_q   <= 12'hFFF;
            p1_s2_q   <= 12'hFFF;
            p2_s1_q   <= 12'hFFF;
            p2_s2_q   <= 12'hFFF;
        end else begin
            jclk_s1_q <= joy_clk;
            jclk_s2_q <= jclk_s1_q;
            jclk_h_q  <= jclk_s2_q;
            jld_s1_q  <= joy_load;
            jld_s2_q  <= jld_s1_q;
            jld_h_q   <= jld_s2_q;
            p1_s1_q   <= p1_btn;
            p1_s2_q   <= p1_s1_q;
            p2_s1_q   <= p2_btn;
            p2_s2_q   <= p2_s1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_SHIFT;
            sr_q     <= 24'hFFFFFF;
            shcnt_q  <= 5'd0;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 8'd0;
            first_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            shcnt_q  <= shcnt_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        shcnt_d  = shcnt_q;
        strobe_d = 1'b0;
        err_d    = err_q;
        cnt_d    = cnt_q;
        first_d  = first_q;

        state_d = jld_s2_q ? ST_SHIFT : ST_LOAD;

        // Load stays in force through the load_rise cycle so a coincident clk_rise is dropped
        load_en = !jld_s2_q || (state_q == ST_LOAD);

        if (load_en) begin
            sr_d = load_word;
        end else if (clk_rise) begin
            sr_d = {sr_q[22:0], FILL_BIT};
            if (shcnt_q != 5'd31) begin
                shcnt_d = shcnt_q + 5'd1;
            end
        end

        if (load_rise) begin
            shcnt_d  = 5'd0;
            strobe_d = 1'b1;
            cnt_d    = cnt_q + 8'd1;
            err_d    = first_q ? 1'b0 : (shcnt_q < 5'd24);
            first_d  = 1'b0;
        end
    end

    assign joy_data     = sr_q[23];
    assign frame_strobe = strobe_q;
    assign frame_err    = err_q;
    assign frame_cnt    = cnt_q;

endmodule

// File: tb/tb_joy_serializer.sv
// tb/tb_joy_serializer.sv - directed bench for joy_serializer
module tb_joy_serializer;

    logic        clk;
    logic        reset;
    logic        joy_clk;
    logic        joy_load;
    logic [11:0] p1_btn;
    logic [11:0] p2_btn;
    logic        joy_data;
    logic        frame_strobe;
    logic        frame_err;
    logic [7:0]  frame_cnt;

    int errors;
    int checks;

    joy_serializer #(.FILL_BIT(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .joy_clk      (joy_clk),
        .joy_load     (joy_load),
        .p1_btn       (p1_btn),
        .p2_btn       (p2_btn),
        .joy_data     (joy_data),
        .frame_strobe (frame_strobe),
        .frame_err    (frame_err),
        .frame_cnt    (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic joy_pulse();
        joy_clk = 1'b1;
        tick(5);
        joy_clk = 1'b0;
        tick(5);
    endtask

    // One decoder frame: load low across one rise, then nshift sampled rises
    task automatic run_frame(input int nshift, input int chg_at, input logic [11:0] chg_p1,
                             output logic [23:0] word, output logic [7:0] fill,
                             output logic err_at, output logic [7:0] cnt_at);
        word = '0;
        fill = '0;
        joy_load = 1'b0;
        tick(3);
        joy_pulse();
        joy_load = 1'b1;
        tick(3);
        check("strobe_high", frame_strobe, 1);
        err_at = frame_err;
        cnt_at = frame_cnt;
        tick(1);
        check("strobe_one_cycle", frame_strobe, 0);
        tick(2);
        for (int i = 0; i < nshift; i++) begin
            if (i == chg_at) p1_btn = chg_p1;
            if (i < 24) word = {word[22:0], joy_data};
            else        fill = {fill[6:0], joy_data};
            joy_pulse();
        end
    endtask

    logic [23:0] w;
    logic [7:0]  f;
    logic        e;
    logic [7:0]  c;

    initial begin
        errors   = 0;
        checks   = 0;
        reset    = 1'b1;
        joy_clk  = 1'b0;
        joy_load = 1'b1;
        p1_btn   = 12'hFFF;
        p2_btn   = 12'hFFF;
        tick(3);
        check("rst_data", joy_data, 1);
        check("rst_strobe", frame_strobe, 0);
        check("rst_err", frame_err, 0);
        check("rst_cnt", frame_cnt, 0);
        reset = 1'b0;
        tick(5);

        run_frame(25, -1, 12'hFFF, w, f, e, c);
        check("idle_err", e, 0);
        check("idle_cnt", c, 1);
        check("idle_word", w, 24'hFFFFFF);
        check("idle_fill", f, 8'h01);

        p1_btn = 12'hEFF;
        run_frame(25, -1, 12'hEFF, w, f, e, c);
        check("p1start_err", e, 0);
        check("p1start_cnt", c, 2);
        check("p1start_word", w, 24'h7FFFFF);

        p1_btn = 12'hFFF;
        p2_btn = 12'hFFE;
        run_frame(25, -1, 12'hFFF, w, f, e, c);
        check("p2up_word", w, 24'hFFFEFF);

        p2_btn = 12'hFFF;
        p1_btn = 12'hF7F;
        run_frame(25, -1, 12'hF7F, w, f, e, c);
        check("p1fire4_word", w, 24'hFFFFFE);

        p1_btn = 12'h000;
        p2_btn = 12'h000;
        run_frame(28, -1, 12'h000, w, f, e, c);
        check("zero_word", w, 24'h000000);
        check("fill_bits", f, 8'h0F);

        p1_btn = 12'hFFF;
        p2_btn = 12'hFFF;
        run_frame(10, -1, 12'hFFF, w, f, e, c);
        check("after28_err", e, 0);
        run_frame(25, -1, 12'hFFF, w, f, e, c);
        check("short_err", e, 1);
        check("short_cnt", c, 7);
        run_frame(25, -1, 12'hFFF, w, f, e, c);
        check("full_err", e, 0);

        run_frame(25, 3, 12'hFFE, w, f, e, c);
        check("midchg_cur_word", w, 24'hFFFFFF);
        run_frame(25, -1, 12'hFFE, w, f, e, c);
        check("midchg_next_word", w, 24'hFEFFFF);

        p1_btn = 12'h000;
        p2_btn = 12'h000;
        run_frame(10, -1, 12'h000, w, f, e, c);
        run_frame(11, -1, 12'h000, w, f, e, c);
        check("pre_reset_err", e, 1);
        check("pre_reset_cnt", c, 12);
        joy_clk = 1'b1;
        tick(3);
        check("pre_reset_data", joy_data, 0);
        reset = 1'b1;
        #2;
        check("midrst_data", joy_data, 1);
        check("midrst_err", frame_err, 0);
        check("midrst_cnt", frame_cnt, 0);
        check("midrst_strobe", frame_strobe, 0);
        tick(2);
        reset = 1'b0;
        joy_clk = 1'b0;
        p1_btn = 12'hFFF;
        p2_btn = 12'hFFF;
        tick(10);

        run_frame(25, -1, 12'hFFF, w, f, e, c);
        check("postrst_first_err", e, 0);
        check("postrst_cnt", c, 1);

        for (int k = 0; k < 255; k++) begin
            run_frame(0, -1, 12'hFFF, w, f, e, c);
        end
        check("wrap_cnt", c, 0);
        check("wrap_err", e, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/joy_serializer.md
# joy_serializer

Serial joystick transmitter: emulates the 74HC165 shift-register chain on the joystick adapter board. It answers the `joy_clk`/`joy_load` pair driven by the joystick decoder with the 24-bit active-low button stream on `joy_data`. It sits on the adapter side of the cable, or in loop-back test fabric, and is fed by parallel button inputs for two players.

## Interface

- `FILL_BIT`, default 1'b1: value shifted in behind the 24 data bits, like the 165 SER pin tied high.
- `clk` in 1: system clock; at least 8x the `joy_clk` frequency.
- `reset` in 1: asynchronous, active-high reset.
- `joy_clk` in 1: shift clock from the decoder, asynchronous to `clk`.
- `joy_load` in 1: parallel-load, active-low, asynchronous to `clk`.
- `p1_btn` in 12: player 1 buttons, active-low, asynchronous. Bit map: [0] up, [1] down, [2] left, [3] right, [4] fire1, [5] fire2, [6] fire3, [7] fire4, [8] start, [9] coin, [10] select, [11] service.
- `p2_btn` in 12: player 2 buttons, active-low, same bit map, except [11] = test.
- `joy_data` out 1: serial data, the current head bit of the shift register.
- `frame_strobe` out 1: one-`clk` pulse when a frame starts, i.e. on the `joy_load` rise.
- `frame_err` out 1: high if the previous frame had fewer than 24 shifts; updated on every `frame_strobe`.
- `frame_cnt` out 8: count of frames, wraps at 255→0.

## Operation

- **Synchronisers.** `joy_clk` and `joy_load` each pass through a 2-FF synchroniser plus one history FF. `p1_btn` and `p2_btn` pass through a 2-FF synchroniser.
- **Edge definitions.**
  - `clk_rise` = synced `joy_clk` 0→1.
  - `load_rise` = synced `joy_load` 0→1.
- **24-bit shift register `sr`.** Head bit is sr[23] and drives `joy_data`. Serial order from head to tail:
  - p1: start, fire3, fire2, fire1, right, left, down, up
  - p2: start, fire3, fire2, fire1, right, left, down, up
  - p2 select, p2 test, p2 coin, p2 fire4
  - p1 select, p1 service, p1 coin, p1 fire4
- **Load.** While synced `joy_load` = 0, `sr` reloads from synced buttons every `clk`. This is transparent, like the 165. `clk_rise` is ignored during load.
- **Shift.** While synced `joy_load` = 1, each `clk_rise` performs `sr <= {sr[22:0], FILL_BIT}`.
  - A `clk_rise` in the same `clk` cycle as `load_rise` does not shift, because load is still seen low.
- **Shift counter `shcnt` (5 bits).**
  - Cleared on `load_rise`.
  - Incremented per shift and saturates at 31.
- **Frame bookkeeping.** On `load_rise`:
  - `frame_err <= (shcnt_prev < 24)`, where `shcnt_prev` is the count before clearing.
  - `frame_cnt` increments.
  - `frame_strobe` pulses for one `clk`.
  - The first `load_rise` after reset does not set `frame_err`; a first-frame flag suppresses it.
- **Decoder frame shape.** The decoder produces 26 `joy_clk` rises per frame. `joy_load` is low across exactly one rise, so the block sees 25 shifts per frame.
  - The decoder samples before each shift. It therefore reads the head, then 23 shifted bits, and then one fill-bit shift at frame end.
- **State machine** (2 states):
  - `LOAD`: entered when synced `joy_load` = 0.
  - `SHIFT`: entered when synced `joy_load` = 1.
  - Transitions follow the synced `joy_load` level only.

## Timing

- Reset values:
  - `sr` = 24'hFFFFFF, so `joy_data` = 1.
  - `frame_strobe` = 0, `frame_err` = 0, `frame_cnt` = 0, `shcnt` = 0.
  - All synchroniser FFs = 1.
  - State = `SHIFT`.
- Input-edge latency: 3 `clk` from a `joy_clk` edge to the `joy_data` update, and 3 `clk` from the `joy_load` rise to `frame_strobe`.
- Button latency: 2 `clk` of synchroniser plus 1 `clk` of load, so 3 `clk` while `joy_load` is low.
- `joy_clk` high and low phases must each last at least 4 `clk`. Then `joy_data` settles at least 1 `clk` before the next `joy_clk` rise at the decoder.
- A `joy_load` low pulse shorter than 3 `clk` may be missed. In that case there is no reload, no strobe, and `shcnt` keeps counting.
- Reset asserted mid-frame: immediate return to reset values. The next `load_rise` counts as the first frame.

## Test plan

- **Idle.** All buttons 1, decoder-style 26-edge frame → 24 sampled bits all 1; `frame_err` = 0; `frame_cnt` = 1 after the first frame.
- **Bit order.** p1 start = 0 only → first sampled bit 0, the rest 1. Repeat with p2 up = 0 → sampled bit 16 is 0. Repeat with p1 fire4 = 0 → sampled bit 24 is 0.
- **Fill bit.** Keep shifting past 24 rises with all buttons 0 → bits 25 and later read `FILL_BIT`.
- **Short frame.** Assert load after 10 shifts → `frame_err` = 1 at the next strobe. A following full frame → `frame_err` = 0.
- **Button change mid-frame.** Toggle p1 up during `SHIFT` → the current frame is unaffected; the next frame reflects the new value.
- **Reset and wrap.** Assert reset during shift 12 → `joy_data` = 1 and counters = 0. After 256 frames, `frame_cnt` = 0.
